lsu_ctrl: RTL and testbench

//  Sequences one data-memory access per load/store leaving decode (mem_to_reg / mem_w_ena).

---
 rtl/lsu_ctrl.sv | 140 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one data-memory access at a time over a valid/ready request channel
// and a read-response channel, stalling the pipeline until the access completes.
module lsu_ctrl #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        rd_addr,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              wb_ena,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    localparam logic [8:0] TimeoutLim = 9'(TIMEOUT);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [8:0]        cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        rdata_d   = rdata_q;
        ok_d      = ok_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        mem_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ld_req || st_req) begin
                    stall   = 1'b1;
                    state_d = StReq;
                    we_d    = st_req;  // store wins when both are asserted
                    addr_d  = addr;
                    wdata_d = wdata;
                    rd_d    = rd_addr;
                    cnt_d   = 8'd0;
                    ok_d    = 1'b0;
                end
            end
            StReq: begin
                stall     = 1'b1;
                mem_valid = 1'b1;
                cnt_d     = cnt_inc[7:0];
                // A completing store beats the timeout; a load still needs its response.
                if (mem_ready && we_q) begin
                    state_d = StDone;
                end else if (cnt_inc == TimeoutLim) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else if (mem_ready) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                stall = 1'b1;
                cnt_d = cnt_inc[7:0];
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    ok_d    = 1'b1;
                    state_d = StDone;
                end else if (cnt_inc == TimeoutLim) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 5'd0;
            rdata_q <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        err       = err_q;
        wb_ena    = (state_q == StDone) && ok_q && (rd_q != 5'd0);
        wb_addr   = wb_ena ? rd_q : 5'd0;
        wb_data   = wb_ena ? rdata_q : '0;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed and random accesses checked against a per-access timeline
// derived from handshake and response delays.
module tb_lsu_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req, st_req;
    logic [63:0] addr, wdata;
    logic [4:0]  rd_addr;
    logic        mem_valid, mem_ready, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        stall, wb_ena;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        err;

    int checks = 0;
    int errors = 0;

    lsu_ctrl #(
        .ADDR_W (64),
        .DATA_W (64),
        .TIMEOUT(T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_req    (ld_req),
        .st_req    (st_req),
        .addr      (addr),
        .wdata     (wdata),
        .rd_addr   (rd_addr),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .wb_ena    (wb_ena),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // kind: 0 load, 1 store, 2 both (treated as store). Cycle 0 is the accept cycle.
    task automatic run_access(input int kind, input logic [63:0] a, input logic [63:0] wd,
                              input logic [4:0] rd, input int rdy_dly, input int rv_dly,
                              input logic [63:0] rdv);
        int h, r, done, req_end;
        bit is_st, aborted, wb_exp, exp_valid;
        is_st = (kind != 0);
        h     = 1 + rdy_dly;
        r     = -1;
        if (is_st) begin
            aborted = (h > T);
            done    = aborted ? T + 1 : h + 1;
        end else if (h >= T) begin
            aborted = 1'b1;
            done    = T + 1;
            r       = h + 1 + rv_dly;
        end else begin
            r       = h + 1 + rv_dly;
            aborted = (r > T);
            done    = aborted ? T + 1 : r + 1;
        end
        req_end = (h < T) ? h : T;
        wb_exp  = !is_st && !aborted && (rd != 5'd0);
        for (int c = 0; c <= done + 2; c++) begin
            ld_req     = (c <= done) && (kind != 1);
            st_req     = (c <= done) && (kind != 0);
            addr       = (c == 0) ? a : rnd64();
            wdata      = (c == 0) ? wd : rnd64();
            rd_addr    = (c == 0) ? rd : 5'($urandom);
            mem_ready  = (c == h);
            mem_rvalid = (c == r) || (c >= 1 && c <= req_end && $urandom_range(0, 1) == 1);
            mem_rdata  = (c == r) ? rdv : rnd64();
            @(negedge clk);
            exp_valid = (c >= 1) && (c <= req_end);
            chk("stall", stall, c < done);
            chk("mem_valid", mem_valid, exp_valid);
            if (exp_valid) begin
                chk("mem_we", mem_we, is_st);
                chk("mem_addr", mem_addr, a);
                chk("mem_wdata", mem_wdata, wd);
            end
            chk("wb_ena", wb_ena, (c == done) && wb_exp);
            if ((c == done) && wb_exp) begin
                chk("wb_addr", wb_addr, rd);
                chk("wb_data", wb_data, rdv);
            end
            chk("err", err, (c == done) && aborted);
            @(posedge clk);
            #1;
        end
        ld_req     = 1'b0;
        st_req     = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_valid"}, mem_valid, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_wb_ena"}, wb_ena, 0);
        chk({tag, "_wb_addr"}, wb_addr, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        rst        = 1'b1;
        ld_req     = 1'b0;
        st_req     = 1'b0;
        addr       = '0;
        wdata      = '0;
        rd_addr    = 5'd0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed scenarios
        run_access(0, 64'h8000_1000, 64'h0, 5'd5, 0, 0, 64'hDEAD_BEEF);
        run_access(1, 64'h8000_2000, 64'h1234, 5'd3, 3, 0, 64'h0);
        run_access(0, 64'h8000_3000, 64'h0, 5'd0, 1, 1, 64'h5555);
        run_access(2, 64'h8000_4000, 64'hABCD, 5'd9, 0, 0, 64'h7777);
        run_access(0, 64'h8000_5000, 64'h0, 5'd6, 20, 0, 64'h9999);
        run_access(1, 64'h8000_6000, 64'h42, 5'd1, 20, 0, 64'h0);
        run_access(0, 64'h8000_7000, 64'h0, 5'd8, 1, 5, 64'h1111);

        // Reset while a load waits for its response
        ld_req  = 1'b1;
        addr    = 64'h8000_8000;
        rd_addr = 5'd7;
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("rst_resp_stall", stall, 1);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        ld_req     = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hCAFE;
        @(negedge clk);
        chk_all_zero("post_rst");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("late_rvalid_wb", wb_ena, 0);
            chk("late_rvalid_stall", stall, 0);
        end
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;

        // Random accesses
        for (int n = 0; n < 60; n++) begin
            run_access(int'($urandom_range(0, 2)), rnd64(), rnd64(), 5'($urandom),
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), rnd64());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
